uart_tx_mmio: RTL and testbench

// - Memory-mapped UART transmitter; consumes the uart_write strobe the address decoder

---
 rtl/uart_tx_mmio.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter.
// Bytes written through uart_write are queued in a small FIFO and sent 8N1 on tx.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_mmio #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_write,
   input  logic [31:0] write_data,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = PTR_W + 1;
   localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Serialiser state
   state_t           state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             push;
   logic             pop;
   logic             baud_tc;
   logic [7:0]       head;

   // Upper store-data bits carry no meaning for this register.
   logic             unused_hi;
   assign unused_hi = ^write_data[31:8];

   assign fifo_full = (count_q == DEPTH_CNT);
   assign push      = uart_write && !fifo_full;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];
   assign baud_tc   = (baud_q == BAUD_LAST);

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign overflow  = ovf_q;

   // FIFO next state: push/pop pointers, occupancy and sticky overflow
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (push) begin
         mem_d[wr_ptr_q] = write_data[7:0];
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      // fifo_full is the pre-edge value, so a write racing a pop while full is still dropped
      if (uart_write && fifo_full) begin
         ovf_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Frame FSM next state, baud/bit counters, and registered line/busy values
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
      busy_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (pop) begin
               shift_d  = head;
`ifdef UART_TX_PARITY_EN
               parity_d = ^head;
`endif
               state_d  = S_START;
            end
         end

         S_START: begin
            if (baud_tc) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_DATA: begin
            if (baud_tc) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tc) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`endif

         S_STOP: begin
            if (baud_tc) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // tx is computed from the next state so the line register changes on the same edge as the FSM
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase

      busy_d = (count_d != '0) || (state_d != S_IDLE);
   end

   // Frame FSM registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Frames on tx are decoded by a mid-bit sampler and compared with an expected-byte queue.
module tb_uart_tx_mmio;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   typedef logic [FB-1:0] frame_t;

   typedef struct {
      logic [31:0] wdata;
      logic [7:0]  exp_byte;
      logic        exp_par;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_write = 1'b0;
   logic [31:0] write_data = '0;
   logic        tx;
   logic        busy;
   logic        fifo_full;
   logic        overflow;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   logic [7:0]  exp_q [$];
   frame_t      frames [$];

   uart_tx_mmio #(
      .CLK_FREQ   (16),
      .BAUD       (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_write (uart_write),
      .write_data (write_data),
      .tx         (tx),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected line frame for a byte: start 0, data LSB first, optional even parity, stop 1
   function automatic frame_t model_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call at a negedge; the write is taken on the following posedge
   task automatic do_write(input logic [31:0] d);
      write_data = d;
      uart_write = 1'b1;
      @(negedge clk);
      uart_write = 1'b0;
   endtask

   task automatic drain(input string tag);
      int unsigned t = 0;
      frame_t      f;
      logic [7:0]  b;
      while (busy !== 1'b0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_drain_done"}, 32'(t < 5000), 32'd1);
      repeat (4) @(negedge clk);
      chk({tag, "_frame_count"}, 32'(frames.size()), 32'(exp_q.size()));
      while (frames.size() != 0 && exp_q.size() != 0) begin
         f = frames.pop_front();
         b = exp_q.pop_front();
         chk({tag, "_frame"}, 32'(f), 32'(model_frame(b)));
      end
      frames.delete();
      exp_q.delete();
   endtask

   // Line decoder: detect start edge, sample each bit at its middle
   initial begin
      bit     active = 1'b0;
      int     cyc = 0;
      frame_t bits = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1'b1;
               cyc    = 0;
            end
         end else begin
            cyc++;
         end
         if (active && (cyc % CPB == CPB / 2)) begin
            bits[cyc / CPB] = tx;
            if (cyc / CPB == FB - 1) begin
               frames.push_back(bits);
               active = 1'b0;
            end
         end
      end
   end

   initial begin
      vec_t        vecs [6];
      frame_t      f;
      int unsigned lows;
      int unsigned len;
      logic [31:0] d;

      vecs[0] = '{32'hDEAD_BEA5, 8'hA5, 1'b0};
      vecs[1] = '{32'h0000_0007, 8'h07, 1'b1};
      vecs[2] = '{32'hFFFF_FF03, 8'h03, 1'b0};
      vecs[3] = '{32'h1234_5680, 8'h80, 1'b1};
      vecs[4] = '{32'hABCD_EF00, 8'h00, 1'b0};
      vecs[5] = '{32'h0000_00FF, 8'hFF, 1'b0};

      // Reset held three cycles, then outputs must hold after release
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_full", 32'(fifo_full), 32'd0);
         chk("rst_ovf", 32'(overflow), 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_tx", 32'(tx), 32'd1);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end

      // Table-driven single-byte frames, checked every cycle of the frame
      for (int k = 0; k < 6; k++) begin
`ifdef UART_TX_PARITY_EN
         f = {1'b1, vecs[k].exp_par, vecs[k].exp_byte, 1'b0};
`else
         f = {1'b1, vecs[k].exp_byte, 1'b0};
`endif
         do_write(vecs[k].wdata);
         exp_q.push_back(vecs[k].exp_byte);
         chk($sformatf("vec%0d_pre_tx", k), 32'(tx), 32'd1);
         chk($sformatf("vec%0d_pre_busy", k), 32'(busy), 32'd1);
         for (int i = 0; i < FB; i++) begin
            for (int j = 0; j < CPB; j++) begin
               @(negedge clk);
               chk($sformatf("vec%0d_bit%0d_cyc%0d", k, i, j), 32'(tx), 32'(f[i]));
            end
         end
         @(negedge clk);
         chk($sformatf("vec%0d_end_busy", k), 32'(busy), 32'd0);
         chk($sformatf("vec%0d_end_tx", k), 32'(tx), 32'd1);
      end
      drain("table");

      // Push timed on the same edge that IDLE pops the only queued byte
      do_write(32'h0000_00C3);
      exp_q.push_back(8'hC3);
      repeat (20) @(negedge clk);
      do_write(32'h0000_003C);
      exp_q.push_back(8'h3C);
      repeat (FB * CPB + 1 - 21) @(negedge clk);
      chk("gap_tx", 32'(tx), 32'd1);
      chk("gap_busy", 32'(busy), 32'd1);
      do_write(32'h0000_0099);
      exp_q.push_back(8'h99);
      chk("pushpop_start_tx", 32'(tx), 32'd0);
      chk("pushpop_full", 32'(fifo_full), 32'd0);
      drain("pushpop");

      // Random bursts (1..5 back-to-back writes from an empty, idle transmitter)
      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(5, 1);
         for (int unsigned w = 0; w < len; w++) begin
            d = $urandom;
            do_write(d);
            exp_q.push_back(d[7:0]);
         end
         chk("rand_busy", 32'(busy), 32'd1);
         chk("rand_full", 32'(fifo_full), 32'(len == 5));
         chk("rand_ovf", 32'(overflow), 32'd0);
         drain("rand");
      end

      // Fill to full, then one more write is dropped and overflow sticks
      for (int i = 0; i < 5; i++) begin
         do_write(32'h0000_0011 + 32'(i));
         exp_q.push_back(8'h11 + 8'(i));
      end
      chk("fill_full", 32'(fifo_full), 32'd1);
      chk("fill_ovf_before", 32'(overflow), 32'd0);
      do_write(32'h0000_0016);
      chk("fill_full_after", 32'(fifo_full), 32'd1);
      chk("fill_ovf", 32'(overflow), 32'd1);
      drain("fill");
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Reset in the middle of data bit 3 of 0x5A aborts the frame
      do_write(32'h0000_005A);
      repeat (70) @(negedge clk);
      chk("midrst_bit3", 32'(tx), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_tx", 32'(tx), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_full", 32'(fifo_full), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      lows = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("midrst_idle_line", lows, 32'd0);
      chk("midrst_no_frames", 32'(frames.size()), 32'd0);
      chk("midrst_idle_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
